// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier slice.
//   MULT_WIDTH : operand width; the product is 2*MULT_WIDTH bits
//   MULT_ITERS : number of shift-add iterations for a full-length multiply
//   state_t    : control FSM encoding (IDLE, RUN, DONE)
// No ports; imported by the interface, the datapath step and the top.
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier32_if.sv
// ----------------------------------------------------------------------------
// seq_multiplier32_if
// Start/busy/done handshake between the control unit and the multiplier.
//   start   : control -> multiplier, request a new product
//   a, b    : control -> multiplier, multiplicand / multiplier operands
//   busy    : multiplier -> control, iteration in progress
//   done    : multiplier -> control, one-cycle completion pulse
//   product : multiplier -> control, 2*WIDTH-bit result
// Modports: master (control unit side), slave (multiplier side).
// ----------------------------------------------------------------------------
interface seq_multiplier32_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/mult_step.sv
// ----------------------------------------------------------------------------
// mult_step
// One combinational shift-add iteration of the multiplier datapath.
//   acc      in  WIDTH : upper half of the running {acc,mq} register
//   mq       in  WIDTH : lower half; bit 0 is the multiplier bit being consumed
//   mcand    in  WIDTH : multiplicand
//   acc_next out WIDTH : upper half after conditional add and 1-bit right shift
//   mq_next  out WIDTH : lower half after the shift
// ----------------------------------------------------------------------------
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mq_next
);

    logic [WIDTH:0] sum;

    // The add is one bit wider than the operands so the carry is kept; the
    // right shift then moves that carry into the top bit of acc, and the low
    // sum bit drops into the vacated top of mq.
    always_comb begin
        sum      = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
        acc_next = sum[WIDTH:1];
        mq_next  = {sum[0], mq[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_multiplier32.sv
// ----------------------------------------------------------------------------
// seq_multiplier32
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier for the
// execute stage. One conditional add plus one right shift per RUN cycle.
//   clk  in  : rising-edge clock
//   rst  in  : synchronous active-high reset
//   bus  slave modport of seq_multiplier32_if (start, a, b, busy, done, product)
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero by aligning {acc,mq} in a single cycle. The
// product is identical; only the latency shrinks. Without the macro every
// multiply takes a fixed WIDTH RUN cycles and no barrel shifter exists.
// ----------------------------------------------------------------------------
module seq_multiplier32
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    seq_multiplier32_if.slave bus
);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mq;
    logic [WIDTH-1:0]     acc_step;
    logic [WIDTH-1:0]     mq_step;
    logic [2*WIDTH-1:0]   run_next;
    logic [2*WIDTH-1:0]   product;
    logic                 last_iter;
    logic                 load;
    logic                 busy_c;
    logic                 done_c;

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .mq       (mq),
        .mcand    (mcand),
        .acc_next (acc_step),
        .mq_next  (mq_step)
    );

`ifdef MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0] remaining;
    logic             early;
    logic [CNT_W:0]   align_amt;

    // After cnt steps only the low WIDTH-cnt bits of mq are still multiplier
    // bits. If they are all zero the remaining steps would only shift, so do
    // the whole remaining shift at once and finish.
    always_comb begin
        remaining = mq & ({WIDTH{1'b1}} >> cnt);
        early     = (remaining == '0);
        align_amt = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
        run_next  = early ? ({acc, mq} >> align_amt) : {acc_step, mq_step};
        last_iter = early || (cnt == CNT_W'(WIDTH-1));
    end
`else
    // Fixed-length multiply: every RUN cycle is a plain shift-add step.
    always_comb begin
        run_next  = {acc_step, mq_step};
        last_iter = (cnt == CNT_W'(WIDTH-1));
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. A start is only taken in IDLE or
    // DONE, so a start arriving in DONE chains straight into the next RUN.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. The product register only changes on the cycle
    // leaving RUN, so it stays valid through a back-to-back restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            product <= '0;
        end else if (load) begin
            cnt     <= '0;
            mcand   <= bus.a;
            acc     <= '0;
            mq      <= bus.b;
        end else if (state == RUN) begin
            cnt       <= cnt + 1'b1;
            {acc, mq} <= run_next;
            if (last_iter) begin
                product <= run_next;
            end
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.product = product;

endmodule

// File: tb/tb_seq_multiplier32.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier32
// Directed self-checking bench for seq_multiplier32. Expected latencies follow
// the build: fixed 33 cycles, or min(msb(b)+2,32)+1 with MULT_EARLY_EXIT_EN.
// ----------------------------------------------------------------------------
module tb_seq_multiplier32;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_multiplier32_if bus ();

    seq_multiplier32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycles from the accepting edge to the first cycle with done high.
    function automatic int expLatency(input logic [31:0] b);
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) msb = i;
        end
        if (!EARLY_EXIT || msb >= 30) return 33;
        return msb + 3;
    endfunction

    task automatic applyStimulus(input logic s, input logic [31:0] av, input logic [31:0] bv);
        bus.start = s;
        bus.a     = av;
        bus.b     = bv;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply from IDLE/DONE and wait (bounded) for done. Operands
    // are scrambled after acceptance to show they are not re-sampled.
    task automatic runOp(input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] expected, input string tag);
        int n;
        int busy_n;
        n      = 0;
        busy_n = 0;
        applyStimulus(1'b1, av, bv);
        do begin
            stepCycle();
            n++;
            if (n == 1) applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
            if (bus.busy) busy_n++;
        end while (!bus.done && n < 100);
        checkOutput({tag, "_latency"}, 64'(n), 64'(expLatency(bv)));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_n), 64'(expLatency(bv) - 1));
        checkOutput({tag, "_product"}, bus.product, expected);
    endtask

    initial begin
        int          n;
        logic        held;
        logic        seen_done;
        logic [31:0] ra;
        logic [31:0] rb;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0);
        repeat (3) stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_product", bus.product, 64'd0);

        // Small operands.
        runOp(32'd7, 32'd6, 64'd42, "mul_7x6");
        applyStimulus(1'b0, 32'd0, 32'd0);
        stepCycle();
        checkOutput("idle_after_done", 64'(bus.done), 64'd0);

        // All ones exercises the carry out of every add.
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mul_ones");
        applyStimulus(1'b0, 32'd0, 32'd0);
        stepCycle();

        // Reset in the middle of RUN must discard everything.
        applyStimulus(1'b1, 32'd5, 32'hFFFF_FFFF);
        stepCycle();
        applyStimulus(1'b0, 32'd5, 32'hFFFF_FFFF);
        repeat (10) stepCycle();
        checkOutput("run_busy_before_reset", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("rst_run_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_run_done", 64'(bus.done), 64'd0);
        checkOutput("rst_run_product", bus.product, 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            stepCycle();
            if (bus.done) seen_done = 1'b1;
        end
        checkOutput("rst_run_no_late_done", 64'(seen_done), 64'd0);

        // Start held high: a/b changed mid-RUN, then a chained second run.
        applyStimulus(1'b1, 32'h0001_0001, 32'h8000_0003);
        n = 0;
        do begin
            stepCycle();
            n++;
            if (n == 10) applyStimulus(1'b1, 32'd1000, 32'h8000_0000);
        end while (!bus.done && n < 100);
        checkOutput("held_first_period", 64'(n), 64'd33);
        checkOutput("held_first_product", bus.product, 64'h0000_8000_8003_0003);
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!bus.done && n < 100);
        checkOutput("held_second_period", 64'(n), 64'd33);
        checkOutput("held_second_product", bus.product, 64'h0000_01F4_0000_0000);
        applyStimulus(1'b0, 32'd0, 32'd0);
        stepCycle();
        checkOutput("held_release_busy", 64'(bus.busy), 64'd0);

        // Back-to-back: 3x5, then 0x0x123 started in the DONE cycle.
        runOp(32'd3, 32'd5, 64'd15, "b2b_first");
        applyStimulus(1'b1, 32'd0, 32'h0000_0123);
        checkOutput("b2b_done_in_restart", 64'(bus.done), 64'd1);
        n    = 0;
        held = 1'b1;
        do begin
            stepCycle();
            n++;
            if (n == 1) applyStimulus(1'b0, 32'd0, 32'd0);
            if (!bus.done && bus.product !== 64'd15) held = 1'b0;
        end while (!bus.done && n < 100);
        checkOutput("b2b_first_held", 64'(held), 64'd1);
        checkOutput("b2b_second_latency", 64'(n), 64'(expLatency(32'h0000_0123)));
        checkOutput("b2b_second_product", bus.product, 64'd0);
        stepCycle();

        // Latency boundaries (early exit shortens the first two).
        runOp(32'd5, 32'd0, 64'd0, "b_zero");
        stepCycle();
        runOp(32'd9, 32'd1, 64'd9, "b_one");
        stepCycle();
        runOp(32'd3, 32'h8000_0000, 64'h0000_0001_8000_0000, "b_msb31");
        stepCycle();

        // Random pairs against a reference multiply.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            runOp(ra, rb, {32'd0, ra} * {32'd0, rb}, "random");
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
